spu_mul_pipe: RTL and testbench
===============================

Name: spu_mul_pipe

Overview:
Parametrised even-pipe integer multiply unit for the SPU. It is the successor to the fixed 7-stage FP/multiply delay chain, generalised in SIMD lane count and latency. It adds per-operand RAW scoreboarding, a pipeline hold, partial flush of in-flight entries, a forwarding tap and an occupancy counter. The unit sits beside the FP unit in the even pipe; its results go to the register-file writeback mux.

Parameters:
LANES, 4, number of 32-bit word lanes (data width LANES*32)
LAT, 7, cycles from accept edge to writeback (2..16)
FLUSH_DEPTH, 1, number of youngest in-flight stages killed by flush (0..LAT-1)
ADDR_W, 7, register address width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous reset, active-low
hold  in  1  global freeze of the pipe
in_valid  in  1  instruction presented this cycle
op  in  3  mul_op_t opcode
rt_addr  in  ADDR_W  destination register
reg_write  in  1  instruction writes the register file
ra, rb, rc  in  LANES*32 each  source values; bit 0 is the MSB, lane 0 is bits 0..31
imm  in  10  immediate for MPYI/MPYUI
flush  in  1  branch taken; kill the incoming instruction and the young stages
src_addr_a, src_addr_b, src_addr_c  in  ADDR_W each  source addresses of the issuing instruction
src_use  in  3  per-operand use bits {a,b,c}
stall_raw  out  1  issuing instruction depends on an in-flight result
fwd_valid  out  1  stage LAT-2 holds a writing entry
fwd_addr  out  ADDR_W  its destination
fwd_data  out  LANES*32  its result
wb_valid  out  1  writeback strobe
wb_addr  out  ADDR_W  writeback destination
wb_data  out  LANES*32  writeback value
busy_count  out  $clog2(LAT+1)  number of valid in-flight entries
idle  out  1  busy_count==0

Behaviour:
- Storage: stage registers s[0..LAT-1], each holding {valid, wr, addr, data}. The result is computed combinationally from the inputs and loaded into s[0] on the accept edge; it then shifts one stage per un-held cycle.
- Accept rule: in_valid & !hold & !flush & op!=NOP. NOP or any rejected input loads s[0].valid=0.
- Latency: an entry accepted at edge 1 reaches s[LAT-1] at edge LAT. wb_* is driven combinationally from s[LAT-1].
- Writeback gating: wb_valid = s[LAT-1].valid & s[LAT-1].wr & !hold. When wb_valid=0, wb_addr and wb_data read 0.
- Hold: all stages retain their contents and the input is ignored. An entry in s[LAT-1] writes back exactly once, on the first un-held cycle.
- Flush: clears valid in s[0..FLUSH_DEPTH-1] at the edge, in addition to killing the input; older stages advance normally. Flush together with hold: the kill still applies and nothing advances. Flush has priority over in_valid.
- stall_raw: asserted when, for any operand x with src_use[x]=1, some stage i in 0..LAT-2 has valid & wr & addr==src_addr_x. Purely combinational. s[LAT-1] is excluded because the register file provides write-through. Operands with src_use[x]=0 never match, including address 0.
- Forward tap: fwd_* is taken from s[LAT-2] with the same zeroing rule as wb_*, and is not gated by hold.
- busy_count: a register updated each edge as +accepted − (valid entry leaving s[LAT-1]) − (valid entries killed by flush). It is not recomputed by popcount; a bench assertion checks it equals the popcount.
- Lane arithmetic: w = word i; L = bits 16..31 (low halfword); H = bits 0..15. All results are taken mod 2^32.
  - MPY (1): signed ra.L × signed rb.L
  - MPYU (2): unsigned ra.L × unsigned rb.L
  - MPYH (3): (signed ra.H × signed rb.L) << 16
  - MPYS (4): (signed ra.L × signed rb.L) >>> 16, sign-extended
  - MPYA (5): signed ra.L × signed rb.L + rc.w
  - MPYI (6): signed ra.L × sext(imm)
  - MPYUI (7): unsigned ra.L × unsigned(sext16(imm))
  - NOP (0): no operation.
- Reset (async, reset_n=0): all valid bits 0, busy_count 0, every output 0 except idle=1. Reset mid-operation discards all in-flight entries with no writeback.

Decomposition:
- Package spu_mul_pkg: mul_op_t enum (codes above), LANE_W=32, the stage_t struct.
- Sub-module spu_mul_lane: combinational, one 32-bit lane; takes op, ra.w, rb.w, rc.w and imm, returns the result. It is instantiated LANES times via generate.

Test Plan:
- MPY, lane 0: ra.L=0xFFFE (−2), rb.L=0x0003, rt=5 -> wb_valid at edge LAT, wb_addr=5, word 0=0xFFFFFFFA; busy_count goes 1 then back to 0.
- MPYA: ra.L=0x7FFF, rb.L=0x7FFF, rc=0x00000001 -> 0x3FFF0002. MPYUI with imm=0x3FF -> multiplier 0xFFFF; ra.L=0x0002 gives 0x0001FFFE.
- Back-to-back: issue rt=9, then next cycle src_addr_a=9 with src_use=3'b100 -> stall_raw=1 for LAT-1 cycles, 0 once the entry is in s[LAT-1]; same address with src_use=0 -> stall_raw=0.
- Hold: assert hold for 3 cycles while an entry sits in s[LAT-1] -> wb_valid=0 throughout, exactly one wb pulse after release, busy_count unchanged during hold.
- Flush with FLUSH_DEPTH=2 and entries in s[0], s[1], s[3] -> only the s[3] entry writes back; busy_count decrements by 2 (plus the incoming instruction is not counted).
- Reset asserted with 4 entries in flight -> all outputs 0 and idle=1 immediately (async); no wb after release; LANES=8, LAT=3 build passes the MPY test.

Source files
------------

// File: rtl/spu_mul_pkg.sv
// Shared types for the SPU even-pipe multiply unit: opcodes, lane width and
// per-stage control bits.
package spu_mul_pkg;

  localparam int LANE_W = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MPY   = 3'd1,
    OP_MPYU  = 3'd2,
    OP_MPYH  = 3'd3,
    OP_MPYS  = 3'd4,
    OP_MPYA  = 3'd5,
    OP_MPYI  = 3'd6,
    OP_MPYUI = 3'd7
  } mul_op_t;

  // Control half of a stage; addr/data live in parallel arrays because their
  // widths depend on the instance parameters.
  typedef struct packed {
    logic valid;
    logic wr;
  } stage_t;

  function automatic logic [15:0] sext_imm(input logic [9:0] imm);
    return {{6{imm[9]}}, imm};
  endfunction

endpackage

// File: rtl/spu_mul_lane.sv
// One 32-bit multiply lane. Every opcode maps onto a single 32x32 product of
// sign- or zero-extended halfwords, then a per-op output shaping step.
import spu_mul_pkg::*;

module spu_mul_lane (
  input  mul_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [9:0]  imm,
  output logic [31:0] res
);

  logic [15:0]        x, y;
  logic               sgn;
  logic signed [31:0] xs, ys, p;
  logic               unused_b_hi;

  // Only the low halfword of rb feeds any opcode.
  assign unused_b_hi = ^b[31:16];

  always_comb begin
    x   = a[15:0];
    y   = b[15:0];
    sgn = 1'b1;
    case (op)
      OP_MPYU:  sgn = 1'b0;
      OP_MPYH:  x = a[31:16];
      OP_MPYI:  y = sext_imm(imm);
      OP_MPYUI: begin
        y   = sext_imm(imm);
        sgn = 1'b0;
      end
      default: ;
    endcase
  end

  assign xs = sgn ? {{16{x[15]}}, x} : {16'h0, x};
  assign ys = sgn ? {{16{y[15]}}, y} : {16'h0, y};
  assign p  = xs * ys;

  always_comb begin
    res = '0;
    case (op)
      OP_MPY, OP_MPYU, OP_MPYI, OP_MPYUI: res = p;
      OP_MPYH: res = {p[15:0], 16'h0};
      OP_MPYS: res = {{16{p[31]}}, p[31:16]};
      OP_MPYA: res = p + c;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/spu_mul_pipe.sv
// Even-pipe SIMD integer multiply: LAT-deep result pipe with hold, partial
// flush, RAW scoreboard, forwarding tap and running occupancy count.
import spu_mul_pkg::*;

module spu_mul_pipe #(
  parameter int LANES       = 4,
  parameter int LAT         = 7,
  parameter int FLUSH_DEPTH = 1,
  parameter int ADDR_W      = 7
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       hold,
  input  logic                       in_valid,
  input  logic [2:0]                 op,
  input  logic [ADDR_W-1:0]          rt_addr,
  input  logic                       reg_write,
  input  logic [LANES*32-1:0]        ra,
  input  logic [LANES*32-1:0]        rb,
  input  logic [LANES*32-1:0]        rc,
  input  logic [9:0]                 imm,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          src_addr_a,
  input  logic [ADDR_W-1:0]          src_addr_b,
  input  logic [ADDR_W-1:0]          src_addr_c,
  input  logic [2:0]                 src_use,
  output logic                       stall_raw,
  output logic                       fwd_valid,
  output logic [ADDR_W-1:0]          fwd_addr,
  output logic [LANES*32-1:0]        fwd_data,
  output logic                       wb_valid,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [LANES*32-1:0]        wb_data,
  output logic [$clog2(LAT+1)-1:0]   busy_count,
  output logic                       idle
);

  localparam int DW = LANES * LANE_W;
  localparam int CW = $clog2(LAT + 1);

  mul_op_t           op_e;
  logic [DW-1:0]     res;
  logic              accept, leave;
  logic [CW-1:0]     kill_cnt;

  stage_t            ctl  [LAT];
  logic [ADDR_W-1:0] addr [LAT];
  logic [DW-1:0]     data [LAT];

  assign op_e   = mul_op_t'(op);
  assign accept = in_valid & ~hold & ~flush & (op_e != OP_NOP);
  assign leave  = ctl[LAT-1].valid & ~hold;

  // Lane 0 sits in the most significant word (bit 0 is the MSB).
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int HI = (LANES - g) * LANE_W - 1;
    spu_mul_lane u_lane (
      .op  (op_e),
      .a   (ra[HI -: LANE_W]),
      .b   (rb[HI -: LANE_W]),
      .c   (rc[HI -: LANE_W]),
      .imm (imm),
      .res (res[HI -: LANE_W])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        ctl[i]  <= '0;
        addr[i] <= '0;
        data[i] <= '0;
      end
    end else if (!hold) begin
      ctl[0]  <= '{valid: accept, wr: reg_write};
      addr[0] <= rt_addr;
      data[0] <= res;
      for (int i = 1; i < LAT; i++) begin
        ctl[i]  <= ctl[i-1];
        addr[i] <= addr[i-1];
        data[i] <= data[i-1];
      end
      // Killed entries are the ones that were in s[0..FLUSH_DEPTH-1] before the shift.
      if (flush)
        for (int i = 1; i <= FLUSH_DEPTH; i++) ctl[i].valid <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < FLUSH_DEPTH; i++) ctl[i].valid <= 1'b0;
    end
  end

  always_comb begin
    kill_cnt = '0;
    if (flush)
      for (int i = 0; i < FLUSH_DEPTH; i++)
        if (ctl[i].valid) kill_cnt = kill_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_count <= '0;
    else          busy_count <= busy_count + CW'(accept) - CW'(leave) - kill_cnt;
  end

  assign idle = (busy_count == '0);

  // s[LAT-1] is left out: the register file writes through on writeback.
  always_comb begin
    stall_raw = 1'b0;
    for (int i = 0; i < LAT - 1; i++)
      if (ctl[i].valid && ctl[i].wr &&
          ((src_use[2] && addr[i] == src_addr_a) ||
           (src_use[1] && addr[i] == src_addr_b) ||
           (src_use[0] && addr[i] == src_addr_c)))
        stall_raw = 1'b1;
  end

  assign fwd_valid = ctl[LAT-2].valid & ctl[LAT-2].wr;
  assign fwd_addr  = fwd_valid ? addr[LAT-2] : '0;
  assign fwd_data  = fwd_valid ? data[LAT-2] : '0;

  assign wb_valid  = ctl[LAT-1].valid & ctl[LAT-1].wr & ~hold;
  assign wb_addr   = wb_valid ? addr[LAT-1] : '0;
  assign wb_data   = wb_valid ? data[LAT-1] : '0;

endmodule

// File: tb/tb_spu_mul_pipe.sv
// Directed bench for spu_mul_pipe: 4-lane/LAT=7/FLUSH_DEPTH=2 main instance
// plus an 8-lane/LAT=3 instance sharing control for the MPY latency check.
module tb_spu_mul_pipe;

  localparam int LN = 4, LT = 7, FD = 2, AW = 7;

  logic           clk = 1'b0, reset_n = 1'b0, hold = 1'b0, in_valid = 1'b0;
  logic           reg_write = 1'b0, flush = 1'b0;
  logic [2:0]     op = '0, src_use = '0;
  logic [AW-1:0]  rt_addr = '0, src_addr_a = '0, src_addr_b = '0, src_addr_c = '0;
  logic [127:0]   ra = '0, rb = '0, rc = '0;
  logic [255:0]   ra2 = '0, rb2 = '0, rc2 = '0;
  logic [9:0]     imm = '0;

  logic           stall_raw, fwd_valid, wb_valid, idle;
  logic [AW-1:0]  fwd_addr, wb_addr;
  logic [127:0]   fwd_data, wb_data;
  logic [2:0]     busy_count;

  logic           stall2_unused, fwd2_valid_unused, wb2_valid, idle2;
  logic [AW-1:0]  fwd2_addr_unused, wb2_addr;
  logic [255:0]   fwd2_data_unused, wb2_data;
  logic [1:0]     busy2_unused;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  spu_mul_pipe #(.LANES(LN), .LAT(LT), .FLUSH_DEPTH(FD), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset_n(reset_n), .hold(hold), .in_valid(in_valid), .op(op),
    .rt_addr(rt_addr), .reg_write(reg_write), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
    .flush(flush), .src_addr_a(src_addr_a), .src_addr_b(src_addr_b),
    .src_addr_c(src_addr_c), .src_use(src_use), .stall_raw(stall_raw),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_count(busy_count), .idle(idle)
  );

  spu_mul_pipe #(.LANES(8), .LAT(3), .FLUSH_DEPTH(1), .ADDR_W(AW)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .hold(hold), .in_valid(in_valid), .op(op),
    .rt_addr(rt_addr), .reg_write(reg_write), .ra(ra2), .rb(rb2), .rc(rc2), .imm(imm),
    .flush(flush), .src_addr_a(src_addr_a), .src_addr_b(src_addr_b),
    .src_addr_c(src_addr_c), .src_use(src_use), .stall_raw(stall2_unused),
    .fwd_valid(fwd2_valid_unused), .fwd_addr(fwd2_addr_unused), .fwd_data(fwd2_data_unused),
    .wb_valid(wb2_valid), .wb_addr(wb2_addr), .wb_data(wb2_data),
    .busy_count(busy2_unused), .idle(idle2)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [AW-1:0] rt,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [9:0] im);
    in_valid  = 1'b1;
    op        = o;
    rt_addr   = rt;
    reg_write = 1'b1;
    ra  = {4{a}};  rb  = {4{b}};  rc  = {4{c}};
    ra2 = {8{a}};  rb2 = {8{b}};  rc2 = {8{c}};
    imm = im;
  endtask

  logic [2:0]    v_op  [7];
  logic [AW-1:0] v_rt  [7];
  logic [31:0]   v_a   [7], v_b [7], v_c [7], v_exp [7];
  logic [9:0]    v_imm [7];

  initial begin
    int j, pulses;
    logic [AW-1:0] last_addr;

    // op, rt, ra, rb, rc, imm, expected lane word
    v_op[0]=3'd5; v_rt[0]=7'd6;  v_a[0]=32'h00007FFF; v_b[0]=32'h00007FFF; v_c[0]=32'h1; v_imm[0]=10'h0;   v_exp[0]=32'h3FFF0002;
    v_op[1]=3'd7; v_rt[1]=7'd7;  v_a[1]=32'h00000002; v_b[1]=32'h0;        v_c[1]=32'h0; v_imm[1]=10'h3FF; v_exp[1]=32'h0001FFFE;
    v_op[2]=3'd3; v_rt[2]=7'd8;  v_a[2]=32'h0003FFFF; v_b[2]=32'h11110005; v_c[2]=32'h0; v_imm[2]=10'h0;   v_exp[2]=32'h000F0000;
    v_op[3]=3'd4; v_rt[3]=7'd10; v_a[3]=32'h0000FFFF; v_b[3]=32'h00000002; v_c[3]=32'h0; v_imm[3]=10'h0;   v_exp[3]=32'hFFFFFFFF;
    v_op[4]=3'd2; v_rt[4]=7'd11; v_a[4]=32'h0000FFFF; v_b[4]=32'h0000FFFF; v_c[4]=32'h0; v_imm[4]=10'h0;   v_exp[4]=32'hFFFE0001;
    v_op[5]=3'd6; v_rt[5]=7'd12; v_a[5]=32'h00000003; v_b[5]=32'h0;        v_c[5]=32'h0; v_imm[5]=10'h3FE; v_exp[5]=32'hFFFFFFFA;
    v_op[6]=3'd0; v_rt[6]=7'd15; v_a[6]=32'h00000003; v_b[6]=32'h3;        v_c[6]=32'h0; v_imm[6]=10'h0;   v_exp[6]=32'h0;

    // Reset state
    #2;
    chk("rst_wb_valid", 256'(wb_valid), 256'(0));
    chk("rst_busy", 256'(busy_count), 256'(0));
    chk("rst_idle", 256'(idle), 256'(1));
    chk("rst_stall", 256'(stall_raw), 256'(0));
    chk("rst_fwd_valid", 256'(fwd_valid), 256'(0));
    chk("rst_wb_data", 256'(wb_data), 256'(0));
    #10 reset_n = 1'b1;

    // MPY latency: -2 * 3
    issue(3'd1, 7'd5, 32'hABCDFFFE, 32'h00000003, 32'h0, 10'h0);
    tick();
    in_valid = 1'b0;
    chk("mpy_busy1", 256'(busy_count), 256'(1));
    for (int k = 2; k <= LT; k++) begin
      tick();
      if (k == 3) begin
        chk("mpy8_wb_valid", 256'(wb2_valid), 256'(1));
        chk("mpy8_wb_addr", 256'(wb2_addr), 256'(5));
        chk("mpy8_wb_data", wb2_data, {8{32'hFFFFFFFA}});
      end
      if (k == LT - 1) begin
        chk("mpy_early_wb", 256'(wb_valid), 256'(0));
        chk("mpy_fwd_addr", 256'(fwd_addr), 256'(5));
        chk("mpy_fwd_data", 256'(fwd_data), 256'({4{32'hFFFFFFFA}}));
      end
    end
    chk("mpy_wb_valid", 256'(wb_valid), 256'(1));
    chk("mpy_wb_addr", 256'(wb_addr), 256'(5));
    chk("mpy_wb_data", 256'(wb_data), 256'({4{32'hFFFFFFFA}}));
    tick();
    chk("mpy_busy0", 256'(busy_count), 256'(0));
    chk("mpy_wb_done", 256'(wb_valid), 256'(0));

    // Opcode sweep, back-to-back, ending with a NOP that must not count
    for (int k = 0; k < 7; k++) begin
      issue(v_op[k], v_rt[k], v_a[k], v_b[k], v_c[k], v_imm[k]);
      tick();
    end
    in_valid = 1'b0;
    chk("ops_busy", 256'(busy_count), 256'(6));
    j = 0;
    for (int k = 0; k < 20; k++) begin
      if (wb_valid) begin
        if (j < 6) begin
          chk($sformatf("ops_addr%0d", j), 256'(wb_addr), 256'(v_rt[j]));
          chk($sformatf("ops_data%0d", j), 256'(wb_data), 256'({4{v_exp[j]}}));
        end
        j++;
      end
      tick();
    end
    chk("ops_wb_cnt", 256'(j), 256'(6));
    chk("ops_idle", 256'(idle), 256'(1));

    // RAW scoreboard
    issue(3'd1, 7'd9, 32'h1, 32'h1, 32'h0, 10'h0);
    tick();
    in_valid = 1'b0;
    src_addr_a = 7'd9;
    src_use = 3'b100;
    #1 chk("raw_s0", 256'(stall_raw), 256'(1));
    for (int k = 2; k <= LT; k++) begin
      tick();
      chk($sformatf("raw_edge%0d", k), 256'(stall_raw), 256'(k < LT));
      if (k == 3) begin
        src_use = 3'b000;
        #1 chk("raw_nouse", 256'(stall_raw), 256'(0));
        src_addr_c = 7'd9;
        src_use = 3'b001;
        #1 chk("raw_use_c", 256'(stall_raw), 256'(1));
        src_addr_c = 7'd0;
        src_use = 3'b100;
      end
    end
    src_use = 3'b000;
    tick();

    // Hold with an entry parked in the last stage
    issue(3'd1, 7'd13, 32'h2, 32'h2, 32'h0, 10'h0);
    tick();
    in_valid = 1'b0;
    repeat (LT - 1) tick();
    hold = 1'b1;
    issue(3'd1, 7'd14, 32'h2, 32'h2, 32'h0, 10'h0);
    #1;
    chk("hold_wb0", 256'(wb_valid), 256'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold_wb%0d", k + 1), 256'(wb_valid), 256'(0));
      chk($sformatf("hold_busy%0d", k + 1), 256'(busy_count), 256'(1));
    end
    hold = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("hold_rel_wb", 256'(wb_valid), 256'(1));
    chk("hold_rel_addr", 256'(wb_addr), 256'(13));
    tick();
    chk("hold_once", 256'(wb_valid), 256'(0));
    chk("hold_busy_end", 256'(busy_count), 256'(0));

    // Flush kills s[0], s[1] and the incoming op; s[3] survives
    issue(3'd1, 7'd20, 32'h3, 32'h3, 32'h0, 10'h0);
    tick();
    in_valid = 1'b0;
    tick();
    issue(3'd1, 7'd21, 32'h3, 32'h3, 32'h0, 10'h0);
    tick();
    issue(3'd1, 7'd22, 32'h3, 32'h3, 32'h0, 10'h0);
    tick();
    chk("flush_busy_pre", 256'(busy_count), 256'(3));
    flush = 1'b1;
    issue(3'd1, 7'd23, 32'h3, 32'h3, 32'h0, 10'h0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy_post", 256'(busy_count), 256'(1));
    pulses = 0;
    last_addr = '0;
    for (int k = 0; k < 10; k++) begin
      if (wb_valid) begin
        pulses++;
        last_addr = wb_addr;
      end
      tick();
    end
    chk("flush_wb_cnt", 256'(pulses), 256'(1));
    chk("flush_wb_addr", 256'(last_addr), 256'(20));

    // Asynchronous reset with four entries in flight
    for (int k = 0; k < 4; k++) begin
      issue(3'd1, 7'(30 + k), 32'h4, 32'h4, 32'h0, 10'h0);
      tick();
    end
    in_valid = 1'b0;
    chk("arst_busy_pre", 256'(busy_count), 256'(4));
    src_addr_a = 7'd30;
    src_use = 3'b100;
    #1 chk("arst_stall_pre", 256'(stall_raw), 256'(1));
    #1 reset_n = 1'b0;
    #1;
    chk("arst_busy", 256'(busy_count), 256'(0));
    chk("arst_idle", 256'(idle), 256'(1));
    chk("arst_stall", 256'(stall_raw), 256'(0));
    chk("arst_wb", 256'(wb_valid), 256'(0));
    chk("arst_idle8", 256'(idle2), 256'(1));
    @(negedge clk);
    reset_n = 1'b1;
    src_use = 3'b000;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (wb_valid) pulses++;
    end
    chk("arst_no_wb", 256'(pulses), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
